mem_req_router: RTL

Routes the CPU core's data-side SRAM-like request stream to one of NUM_TGT memory targets, such as the cached Dcache path, the uncached bridge path, or future MMIO ports. It replaces the fixed two-way cache/uncache split at the top level. It tracks outstanding requests so that data_ok and rdata always come from the target that owns the oldest request. Responses are therefore returned to the core strictly in order. It sits between mycpu_core and the cache/bridge instances in mycpu_top.

---
 rtl/mem_router_pkg.sv | 17 +
 rtl/router_outs_ctr.sv | 32 +++
 rtl/mem_req_router.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_router_pkg.sv
// Shared definitions for the data-side request router: access-size encodings,
// target limit and a width helper that never returns zero.
package mem_router_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  localparam int unsigned MAX_TGT = 8;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/router_outs_ctr.sv
// Outstanding-request counter for mem_req_router: counts accepts minus
// responses, saturating bounds are guaranteed by the caller's issue gating.
module router_outs_ctr
  import mem_router_pkg::*;
#(
  parameter int unsigned MAX_OUTS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 inc,
  input  logic                                 dec,
  output logic [clog2_min1(MAX_OUTS + 1)-1:0]  cnt,
  output logic                                 full,
  output logic                                 empty
);

  localparam int unsigned CNT_W = clog2_min1(MAX_OUTS + 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign full  = (cnt == CNT_W'(MAX_OUTS));
  assign empty = (cnt == '0);

endmodule

// File: rtl/mem_req_router.sv
// Routes the core's SRAM-like data requests to one of NUM_TGT targets, keeping
// responses in order. Define ROUTER_RSP_REG_EN to register cpu_data_ok/cpu_rdata.
module mem_req_router
  import mem_router_pkg::*;
#(
  parameter int unsigned NUM_TGT  = 2,
  parameter int unsigned MAX_OUTS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cpu_req,
  input  logic                               cpu_wr,
  input  logic [1:0]                         cpu_size,
  input  logic [DATA_W/8-1:0]                cpu_wstrb,
  input  logic [ADDR_W-1:0]                  cpu_addr,
  input  logic [DATA_W-1:0]                  cpu_wdata,
  input  logic [clog2_min1(NUM_TGT)-1:0]     cpu_sel,
  output logic                               cpu_addr_ok,
  output logic                               cpu_data_ok,
  output logic [DATA_W-1:0]                  cpu_rdata,
  output logic [NUM_TGT-1:0]                 tgt_req,
  output logic                               tgt_wr,
  output logic [1:0]                         tgt_size,
  output logic [DATA_W/8-1:0]                tgt_wstrb,
  output logic [ADDR_W-1:0]                  tgt_addr,
  output logic [DATA_W-1:0]                  tgt_wdata,
  input  logic [NUM_TGT-1:0]                 tgt_addr_ok,
  input  logic [NUM_TGT-1:0]                 tgt_data_ok,
  input  logic [NUM_TGT*DATA_W-1:0]          tgt_rdata,
  output logic                               err_stray
);

  localparam int unsigned SEL_W = clog2_min1(NUM_TGT);
  localparam int unsigned CNT_W = clog2_min1(MAX_OUTS + 1);

  if (NUM_TGT < 2 || NUM_TGT > MAX_TGT) begin : g_bad_num_tgt
    $error("mem_req_router: NUM_TGT out of range");
  end

  logic [SEL_W-1:0]  cur_tgt;
  logic [CNT_W-1:0]  outs_cnt;
  logic              outs_full;
  logic              outs_empty;
  logic              sel_valid;
  logic              sel_addr_ok;
  logic              issue_ok;
  logic              accept;
  logic              response;
  logic              stray;
  logic              hold_switch;
  logic [DATA_W-1:0] cur_rdata;

  assign tgt_wr    = cpu_wr;
  assign tgt_size  = cpu_size;
  assign tgt_wstrb = cpu_wstrb;
  assign tgt_addr  = cpu_addr;
  assign tgt_wdata = cpu_wdata;

  always_comb begin
    sel_valid   = 1'b0;
    sel_addr_ok = 1'b0;
    cur_rdata   = '0;
    response    = 1'b0;
    stray       = 1'b0;
    tgt_req     = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (cpu_sel == SEL_W'(i)) begin
        sel_valid   = 1'b1;
        sel_addr_ok = tgt_addr_ok[i];
      end
      if (cur_tgt == SEL_W'(i)) begin
        cur_rdata = tgt_rdata[i*DATA_W +: DATA_W];
        response  = tgt_data_ok[i] & ~outs_empty;
      end
      if (tgt_data_ok[i] && (cur_tgt != SEL_W'(i) || outs_empty)) begin
        stray = 1'b1;
      end
    end
    // A different target may only be chosen once nothing is in flight.
    issue_ok = sel_valid & ~outs_full &
               ((cpu_sel == cur_tgt) | (outs_empty & ~hold_switch));
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      tgt_req[i] = cpu_req & issue_ok & (cpu_sel == SEL_W'(i));
    end
    accept = cpu_req & issue_ok & sel_addr_ok;
  end

  assign cpu_addr_ok = accept;

`ifdef ROUTER_RSP_REG_EN
  logic              data_ok_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= response;
      if (response) begin
        rdata_q <= cur_rdata;
      end
    end
  end

  assign cpu_data_ok = data_ok_q;
  assign cpu_rdata   = rdata_q;
  // Counter has already drained; hold a switch until the last response is out.
  assign hold_switch = data_ok_q;
`else
  assign cpu_data_ok = response;
  assign cpu_rdata   = cur_rdata;
  assign hold_switch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_tgt   <= '0;
      err_stray <= 1'b0;
    end else begin
      if (accept) begin
        cur_tgt <= cpu_sel;
      end
      if (stray) begin
        err_stray <= 1'b1;
      end
    end
  end

  router_outs_ctr #(
    .MAX_OUTS(MAX_OUTS)
  ) u_outs_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .dec   (response),
    .cnt   (outs_cnt),
    .full  (outs_full),
    .empty (outs_empty)
  );

endmodule
